ace_snapshot_packer: RTL and testbench

ACE_SNAPSHOT_PACKER -- requirements
Module: ace_snapshot_packer

---
 rtl/jupiter_pkg.sv | 30 +++
 rtl/ace_pack_outreg.sv | 35 +++
 rtl/ace_snapshot_packer.sv | 221 ++++++++++++++++++++++
 tb/tb_ace_snapshot_packer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jupiter_pkg.sv
// Shared Jupiter Ace constants, packer state encoding and run-flush helper.
package jupiter_pkg;

  localparam logic [7:0]  ACE_ESC      = 8'hED;
  localparam logic [15:0] ACE_RAM_BASE = 16'h2000;
  localparam logic [7:0]  ACE_MAX_RUN  = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    READ,
    WAIT,
    CMP,
    LIT,
    ESC_ED,
    ESC_CNT,
    ESC_VAL,
    END_ED,
    END_00,
    DONE
  } ace_pack_state_e;

  // A run goes out as an escape triple when it is long enough to pay off,
  // or when the byte is the escape code itself (a bare ED would be misread).
  function automatic logic ace_run_is_esc(input logic [7:0] cur,
                                          input logic [7:0] len,
                                          input int         min_run);
    return (int'(len) >= min_run) || (cur == ACE_ESC);
  endfunction

endpackage

// File: rtl/ace_pack_outreg.sv
// Output holding register for the packed byte stream. Data and valid are
// registered so out_valid never depends on the consumer's ready.
module ace_pack_outreg (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_clear,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_accept
);

  logic [7:0] r_data;
  logic       r_valid;

  // Load wins over clear; data only moves on a load, so it is stable while stalled.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data   = r_data;
  assign o_valid  = r_valid;
  assign o_accept = r_valid && i_ready;

endmodule

// File: rtl/ace_snapshot_packer.sv
// Packs Ace RAM START_ADDR..END_ADDR into the .ACE run-length stream:
// literals, ED,n,b for runs, ED,00 as terminator.
module ace_snapshot_packer
  import jupiter_pkg::*;
#(
  parameter logic [15:0] START_ADDR = ACE_RAM_BASE,
  parameter logic [15:0] END_ADDR   = 16'hFFFF,
  parameter int          MIN_RUN    = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        cpu_hold,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_len
);

  // 17-bit address space so END_ADDR=FFFF ends at 10000 instead of wrapping.
  localparam logic [16:0] START_EXT = {1'b0, START_ADDR};
  localparam logic [16:0] END_EXT   = {1'b0, END_ADDR};

  ace_pack_state_e r_state, w_state_nxt;

  logic [16:0] r_addr;      // next address to read
  logic [7:0]  r_cur;       // byte of the run being built
  logic [7:0]  r_len;       // its length, 1..255
  logic [7:0]  r_nxt;       // byte that broke the run, waiting for the flush
  logic [7:0]  r_cnt;       // literal copies still to emit
  logic        r_have;      // r_cur/r_len hold a run
  logic        r_pend;      // r_nxt must start the next run after the flush
  logic [16:0] r_out_len;

  logic       w_more, w_same, w_accept, w_start_acc;
  logic       w_load, w_clear;
  logic [7:0] w_ld_data;
  logic       w_fl_go, w_fl_end;
  logic [7:0] w_fl_cur, w_fl_len;
  logic       w_take, w_grow, w_split, w_promote, w_cnt_dec;

  assign w_more      = (r_addr <= END_EXT);
  assign w_same      = r_have && (mem_dout == r_cur) && (r_len != ACE_MAX_RUN);
  assign w_start_acc = (r_state == IDLE) && start;

  ace_pack_outreg u_outreg (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .i_load   (w_load),
    .i_clear  (w_clear),
    .i_data   (w_ld_data),
    .i_ready  (out_ready),
    .o_data   (out_data),
    .o_valid  (out_valid),
    .o_accept (w_accept)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, read strobe and the byte to load into the output register.
  // WAIT keeps reading back-to-back while the run continues; a run break or
  // the end of memory goes through CMP, which starts the flush.
  always_comb begin
    w_state_nxt = r_state;
    mem_rd      = 1'b0;
    done        = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_ld_data   = r_cur;
    w_fl_go     = 1'b0;
    w_fl_end    = 1'b0;
    w_fl_cur    = r_cur;
    w_fl_len    = r_len;
    w_take      = 1'b0;
    w_grow      = 1'b0;
    w_split     = 1'b0;
    w_promote   = 1'b0;
    w_cnt_dec   = 1'b0;

    unique case (r_state)
      IDLE: if (start) w_state_nxt = READ;
      READ: begin
        mem_rd      = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (!r_have)     w_take  = 1'b1;
        else if (w_same) w_grow  = 1'b1;
        else             w_split = 1'b1;
        if (!w_split && w_more) mem_rd = 1'b1;
        else                    w_state_nxt = CMP;
      end
      CMP: w_fl_go = 1'b1;
      LIT: if (w_accept) begin
        if (r_cnt != 8'd1) begin
          w_cnt_dec = 1'b1;
          w_load    = 1'b1;
          w_ld_data = r_cur;
        end else begin
          w_fl_end = 1'b1;
        end
      end
      ESC_ED: if (w_accept) begin
        w_state_nxt = ESC_CNT;
        w_load      = 1'b1;
        w_ld_data   = r_len;
      end
      ESC_CNT: if (w_accept) begin
        w_state_nxt = ESC_VAL;
        w_load      = 1'b1;
        w_ld_data   = r_cur;
      end
      ESC_VAL: if (w_accept) w_fl_end = 1'b1;
      END_ED: if (w_accept) begin
        w_state_nxt = END_00;
        w_load      = 1'b1;
        w_ld_data   = 8'h00;
      end
      END_00: if (w_accept) begin
        w_state_nxt = DONE;
        w_clear     = 1'b1;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // A flush just finished: continue reading, flush the held byte as the
    // final one-byte run, or terminate.
    if (w_fl_end) begin
      if (r_pend) begin
        w_promote = 1'b1;
        if (w_more) begin
          w_state_nxt = READ;
          w_clear     = 1'b1;
        end else begin
          w_fl_go  = 1'b1;
          w_fl_cur = r_nxt;
          w_fl_len = 8'd1;
        end
      end else begin
        w_state_nxt = END_ED;
        w_load      = 1'b1;
        w_ld_data   = ACE_ESC;
      end
    end

    // Start flushing (w_fl_cur, w_fl_len) with its first byte.
    if (w_fl_go) begin
      w_load = 1'b1;
      if (ace_run_is_esc(w_fl_cur, w_fl_len, MIN_RUN)) begin
        w_state_nxt = ESC_ED;
        w_ld_data   = ACE_ESC;
      end else begin
        w_state_nxt = LIT;
        w_ld_data   = w_fl_cur;
      end
    end
  end

  // Address counter and run tracking.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_addr <= START_EXT;
      r_cur  <= 8'h00;
      r_len  <= 8'h00;
      r_nxt  <= 8'h00;
      r_cnt  <= 8'h00;
      r_have <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_addr <= START_EXT;
        r_have <= 1'b0;
        r_pend <= 1'b0;
      end
      if (mem_rd) r_addr <= r_addr + 17'd1;
      if (w_take) begin
        r_cur  <= mem_dout;
        r_len  <= 8'd1;
        r_have <= 1'b1;
      end
      if (w_grow) r_len <= r_len + 8'd1;
      if (w_split) begin
        r_nxt  <= mem_dout;
        r_pend <= 1'b1;
      end
      if (w_promote) begin
        r_cur  <= r_nxt;
        r_len  <= 8'd1;
        r_pend <= 1'b0;
      end
      if (w_fl_go)        r_cnt <= w_fl_len;
      else if (w_cnt_dec) r_cnt <= r_cnt - 8'd1;
    end
  end

  // Emitted-byte counter, restarted by each accepted start.
  always_ff @(posedge clk_sys) begin
    if (reset)            r_out_len <= 17'd0;
    else if (w_start_acc) r_out_len <= 17'd0;
    else if (w_accept)    r_out_len <= r_out_len + 17'd1;
  end

  assign busy     = (r_state != IDLE);
  assign cpu_hold = busy;
  assign mem_addr = r_addr[15:0];
  assign out_len  = r_out_len;

endmodule

// File: tb/tb_ace_snapshot_packer.sv
// Directed bench for ace_snapshot_packer: one instance per END_ADDR case,
// shared RAM model, byte capture, hold-stability monitor and stream decoder.
module tb_ace_snapshot_packer;

  typedef logic [7:0] bq_t[$];

  localparam logic [15:0] ENDS [5] = '{16'h2003, 16'h212C, 16'h2001, 16'h2002, 16'hFFFF};

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       reset;
  logic [2:0] sel;
  logic       start_p, rdy_set, bp_en, rnd_bit;
  logic       rdy;

  logic        start_v [5];
  logic        busy_v  [5];
  logic        done_v  [5];
  logic        hold_v  [5];
  logic        rd_v    [5];
  logic        val_v   [5];
  logic        rdy_v   [5];
  logic [15:0] addr_v  [5];
  logic [7:0]  dout_v  [5];
  logic [7:0]  data_v  [5];
  logic [16:0] len_v   [5];

  logic [7:0] mem [0:65535];

  assign rdy = bp_en ? rnd_bit : rdy_set;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    assign start_v[g] = (sel == 3'(g)) && start_p;
    assign rdy_v[g]   = (sel == 3'(g)) && rdy;

    ace_snapshot_packer #(
      .START_ADDR (16'h2000),
      .END_ADDR   (ENDS[g]),
      .MIN_RUN    (4)
    ) u_dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .start     (start_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .cpu_hold  (hold_v[g]),
      .mem_addr  (addr_v[g]),
      .mem_rd    (rd_v[g]),
      .mem_dout  (dout_v[g]),
      .out_data  (data_v[g]),
      .out_valid (val_v[g]),
      .out_ready (rdy_v[g]),
      .out_len   (len_v[g])
    );

    always @(posedge clk_sys) if (rd_v[g]) dout_v[g] <= mem[addr_v[g]];
  end

  logic        busy_s, done_s, hold_s, rd_s, val_s;
  logic [15:0] addr_s;
  logic [7:0]  data_s;
  logic [16:0] len_s;
  assign busy_s = busy_v[sel];
  assign done_s = done_v[sel];
  assign hold_s = hold_v[sel];
  assign rd_s   = rd_v[sel];
  assign val_s  = val_v[sel];
  assign addr_s = addr_v[sel];
  assign data_s = data_v[sel];
  assign len_s  = len_v[sel];

  int   n_chk = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   hold_viol = 0;
  logic hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  bq_t  got_q;
  bq_t  exp_q;

  always @(posedge clk_sys) begin
    #1;
    rnd_bit <= 1'($urandom_range(0, 1));
  end

  // Capture accepted bytes, count done pulses, watch stalled data.
  always @(negedge clk_sys) begin
    if (val_s && rdy) got_q.push_back(data_s);
    if (done_s) done_cnt <= done_cnt + 1;
    if (hold_prev && !(val_s && data_s == data_prev)) hold_viol <= hold_viol + 1;
    hold_prev <= val_s && !rdy && !reset;
    data_prev <= data_s;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_start();
    start_p = 1'b1;
    cyc(1);
    start_p = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      cyc(1);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i),
          (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  task automatic run_case(input logic [2:0] s, input string tag);
    int d0;
    sel = s;
    got_q.delete();
    rdy_set = 1'b1;
    d0 = done_cnt;
    do_start();
    wait_done(tag, 3000);
    cyc(3);
    chk({tag, "_busy_after"}, 32'(busy_s), 32'd0);
    chk({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    cmp_stream(tag);
    chk({tag, "_out_len"}, 32'(len_s), exp_q.size());
  endtask

  task automatic fill_full();
    for (int a = 16'h2000; a <= 16'hFFFF; a++) begin
      logic [15:0] aa;
      aa = 16'(a);
      mem[aa] = (aa[11:4] == 8'h03) ? {4'hE, aa[3:0]} : {aa[15:12], aa[11:8]};
    end
  endtask

  // Decode the captured stream as the loader would and compare with RAM.
  task automatic decode_full();
    int i = 0;
    int pos = 16'h2000;
    int nmis = 0;
    int term = 0;
    int n;
    logic [7:0] b;
    while (i < got_q.size() && term == 0 && nmis < 1000) begin
      if (got_q[i] != 8'hED) begin
        if (pos > 16'hFFFF || mem[16'(pos)] != got_q[i]) nmis++;
        pos++;
        i++;
      end else if (i + 1 < got_q.size() && got_q[i+1] == 8'h00) begin
        term = 1;
        i += 2;
      end else if (i + 2 < got_q.size()) begin
        n = int'(got_q[i+1]);
        b = got_q[i+2];
        for (int k = 0; k < n; k++) begin
          if (pos > 16'hFFFF || mem[16'(pos)] != b) nmis++;
          pos++;
        end
        i += 3;
      end else begin
        nmis++;
        i = got_q.size();
      end
    end
    chk("full_decoded_bytes", pos - 16'h2000, 32'd57344);
    chk("full_mismatches", nmis, 32'd0);
    chk("full_terminator", term, 32'd1);
    chk("full_trailing", i, got_q.size());
    chk("full_out_len", 32'(len_s), got_q.size());
  endtask

  initial begin
    int n;
    int d0;
    sel = 3'd0; start_p = 1'b0; rdy_set = 1'b0; bp_en = 1'b0; reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_busy", 32'(busy_s), 32'd0);
    chk("rst_cpu_hold", 32'(hold_s), 32'd0);
    chk("rst_done", 32'(done_s), 32'd0);
    chk("rst_mem_rd", 32'(rd_s), 32'd0);
    chk("rst_out_valid", 32'(val_s), 32'd0);
    chk("rst_mem_addr", 32'(addr_s), 32'h2000);
    chk("rst_out_len", 32'(len_s), 32'd0);
    cyc(1);

    // Four literals, with a second start while busy.
    mem[16'h2000] = 8'h01; mem[16'h2001] = 8'h02;
    mem[16'h2002] = 8'h03; mem[16'h2003] = 8'h04;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hED, 8'h00};
    sel = 3'd0; got_q.delete(); rdy_set = 1'b1; d0 = done_cnt;
    do_start();
    chk("lit_busy", 32'(busy_s), 32'd1);
    chk("lit_cpu_hold", 32'(hold_s), 32'd1);
    n = 0;
    while (len_s != 17'd2 && n < 200) begin cyc(1); n++; end
    rdy_set = 1'b0;
    chk("lit_reach_len2", 32'(len_s), 32'd2);
    do_start();
    cyc(2);
    chk("restart_len_kept", 32'(len_s), 32'd2);
    chk("restart_still_busy", 32'(busy_s), 32'd1);
    rdy_set = 1'b1;
    wait_done("lit", 2000);
    cyc(3);
    chk("lit_done_pulses", done_cnt - d0, 32'd1);
    cmp_stream("lit");
    chk("lit_out_len", 32'(len_s), 32'd6);

    // 300 zeros then 11: reset while in ESC_CNT, then a clean repack.
    for (int a = 16'h2000; a < 16'h212C; a++) mem[16'(a)] = 8'h00;
    mem[16'h212C] = 8'h11;
    sel = 3'd1; got_q.delete(); rdy_set = 1'b0;
    do_start();
    n = 0;
    while (!val_s && n < 2000) begin cyc(1); n++; end
    chk("abort_first_valid", 32'(val_s), 32'd1);
    chk("abort_first_byte", 32'(data_s), 32'hED);
    rdy_set = 1'b1;
    cyc(1);
    rdy_set = 1'b0;
    chk("abort_cnt_valid", 32'(val_s), 32'd1);
    chk("abort_cnt_byte", 32'(data_s), 32'hFF);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("abort_out_valid", 32'(val_s), 32'd0);
    chk("abort_busy", 32'(busy_s), 32'd0);
    chk("abort_cpu_hold", 32'(hold_s), 32'd0);
    chk("abort_out_len", 32'(len_s), 32'd0);
    chk("abort_mem_addr", 32'(addr_s), 32'h2000);
    d0 = done_cnt;
    rdy_set = 1'b1;
    cyc(20);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_no_bytes", got_q.size(), 32'd1);
    exp_q = '{8'hED, 8'hFF, 8'h00, 8'hED, 8'h2D, 8'h00, 8'h11, 8'hED, 8'h00};
    run_case(3'd1, "run300");

    // Lone ED must be escaped.
    mem[16'h2000] = 8'hED; mem[16'h2001] = 8'h05;
    exp_q = '{8'hED, 8'h01, 8'hED, 8'h05, 8'hED, 8'h00};
    run_case(3'd2, "esc1");

    // Run of three stays literal.
    mem[16'h2000] = 8'hAA; mem[16'h2001] = 8'hAA; mem[16'h2002] = 8'hAA;
    exp_q = '{8'hAA, 8'hAA, 8'hAA, 8'hED, 8'h00};
    run_case(3'd3, "run3");

    // Full RAM with random backpressure.
    fill_full();
    sel = 3'd4; got_q.delete(); rdy_set = 1'b0; bp_en = 1'b1; d0 = done_cnt;
    do_start();
    wait_done("full", 95000);
    bp_en = 1'b0;
    cyc(3);
    chk("full_done_pulses", done_cnt - d0, 32'd1);
    chk("full_busy_after", 32'(busy_s), 32'd0);
    decode_full();

    chk("hold_stable_violations", hold_viol, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
